seg7_scan: RTL
==============

Name: seg7_scan

Overview:
- Timed 8-digit seven-segment scanner for the Nexys4DDR board.
- Sits directly downstream of the confreg num_data word. Replaces the free-running counter/mux that drives AN/A2G.
- Adds per-digit blanking dead time to stop ghosting, tear-free per-frame snapshots of the display data, leading-zero blanking, per-digit enables and decimal points.

Parameters:
- DIGITS, 8: number of digits scanned; nibble i of data drives AN[i].
- REFRESH_DIV, 32768: clock cycles per digit slot. At 100 MHz this gives about a 381 Hz frame rate.
- BLANK_CYCLES, 1024: cycles at the start of each slot with all anodes off. Constraint: 1 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- data  in  4*DIGITS  hex value; nibble [4i+3:4i] feeds digit i
- dot  in  DIGITS  dot[i]=1 lights the decimal point of digit i
- digit_en  in  DIGITS  digit_en[i]=0 keeps digit i dark
- lz_blank  in  1  1 = blank leading zero digits
- an  out  DIGITS  anode enables, active-low
- a2g  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- frame_start  out  1  one-cycle pulse when a new frame snapshot is taken

Behaviour:
- Reset: while reset=1, on every edge:
  - an='1, a2g=7'h7F, dp=1, frame_start=0.
  - State=BLANK, digit index idx=0, slot counter cnt=0.
  - Shadow registers cleared.
- Reset asserted mid-operation behaves the same way; the next edge forces these values.
- State machine, cnt width $clog2(REFRESH_DIV):
  - BLANK: cnt counts 0..BLANK_CYCLES-1, then go to DRIVE with cnt continuing.
  - DRIVE: cnt counts BLANK_CYCLES..REFRESH_DIV-1. At REFRESH_DIV-1: cnt<=0, idx<=(idx==DIGITS-1)?0:idx+1, go to BLANK.
- Frame boundary is the cycle with state=BLANK, idx=0, cnt=0, including the first cycle after reset release. In that cycle:
  - data, dot, digit_en and lz_blank are captured into shadow registers.
  - frame_start=1 (registered, visible on the next edge alongside the snapshot).
- Input changes between boundaries have no effect until the next frame.
- Outputs are registered and lag the state register by one cycle:
  - BLANK: an='1, a2g=7'h7F, dp=1.
  - DRIVE with digit visible: an=~(1<<idx), a2g=decode(shadow nibble idx), dp=~shadow_dot[idx].
  - DRIVE with digit not visible: same as BLANK, and the dot is suppressed too.
- Visibility rule: digit idx is visible iff shadow_en[idx]=1 AND NOT (shadow_lz AND idx>0 AND idx>msd).
  - msd is the index of the highest nonzero nibble of shadow data; msd=0 if data is 0.
  - Digit 0 is never leading-zero blanked.
- Decode table, active-low, {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, B=0000011
  - C=1000110, D=0100001, E=0000110, F=0001110
- Timing:
  - Frame period is DIGITS*REFRESH_DIV cycles exactly.
  - Every anode change, digit-to-digit, is separated by at least BLANK_CYCLES cycles of an='1.
  - Two anodes are never low at the same time.
- msd is computed combinationally from the shadow registers, with a priority encoder over DIGITS nibbles.

Decomposition:
- Shared display package holds:
  - seg_state_t enum {BLANK, DRIVE}
  - SEG_OFF = 7'h7F
  - the 16-entry decode constants
- Sub-module: the existing seg7 nibble decoder, instantiated once on the muxed shadow nibble; no per-digit decoders.
- Top level: seg7_scan.data is connected to the confreg num_data, an to AN, a2g to A2G.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2, DIGITS=8):
1. Reset and slot timing:
   - Hold reset 3 cycles -> an=8'hFF, a2g=7'h7F, dp=1.
   - Release -> frame_start pulses once, then every 64 cycles.
   - Each slot shows 2 cycles of an=FF then 6 cycles with one anode low.
2. Basic scan, data=32'h12345678, all enabled, lz_blank=0:
   - Digit 0 slot -> an=8'hFE, a2g=0000000 ('8').
   - Digit 7 slot -> an=8'h7F, a2g=1111001 ('1').
   - Never two anodes low.
3. Leading-zero blanking, lz_blank=1, data=32'h000000A5:
   - Digit 0 shows 0010010 ('5'), digit 1 shows 0001000 ('A').
   - Digits 2-7 keep an=FF.
   - data=0 -> only digit 0 lit, showing 1000000.
4. Tear-free snapshot:
   - data=32'h11111111, switched to 32'h22222222 during digit 3 -> digits 3-7 still show 1111001 for this frame.
   - After the next frame_start, all digits show 0100100 ('2').
5. Enables and dots:
   - dot=8'h02 -> dp=0 only during digit 1 DRIVE.
   - dot=8'h04 with digit_en=8'hFB -> digit 2 slot keeps an=FF and dp=1.
6. Reset mid-scan:
   - Assert reset during digit 5 DRIVE -> next edge gives an=FF.
   - After release, scan restarts at digit 0 with a new frame_start and freshly captured data.

Source files
------------

// File: rtl/seg7_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan_pkg : shared display types and segment constants           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package seg7_scan_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } seg_state_t;

    // All segments dark, active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry n is the active-low glyph for hex digit n
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // D
        7'b1000110,  // C
        7'b0000011,  // B
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage : seg7_scan_pkg
`default_nettype wire

// File: rtl/seg7_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan_if : display data inputs and anode/segment outputs         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface seg7_scan_if #(
    parameter int DIGITS = 8
);
    import seg7_scan_pkg::*;

    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dot;
    logic [DIGITS-1:0]   digit_en;
    logic                lz_blank;
    logic [DIGITS-1:0]   an;
    logic [6:0]          a2g;
    logic                dp;
    logic                frame_start;

    modport master (
        output data, dot, digit_en, lz_blank,
        input  an, a2g, dp, frame_start
    );

    modport slave (
        input  data, dot, digit_en, lz_blank,
        output an, a2g, dp, frame_start
    );

endinterface : seg7_scan_if
`default_nettype wire

// File: rtl/seg7_scan_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan_dec : hex nibble to active-low seven-segment glyph         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seg7_scan_dec
    import seg7_scan_pkg::*;
(
    input  wire logic [3:0] nibble,
    output logic      [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule : seg7_scan_dec
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan : timed multi-digit seven-segment scanner with dead time,  |
// |             per-frame snapshot, leading-zero blanking and enables    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int REFRESH_DIV  = 32768,
    parameter int BLANK_CYCLES = 1024
) (
    input  wire logic  clk,
    input  wire logic  reset,
    seg7_scan_if.slave bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST   = IDX_W'(DIGITS - 1);

    seg_state_t         r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_next;
    logic [IDX_W-1:0]   r_idx,   w_idx_next;

    logic [4*DIGITS-1:0] r_sh_data;
    logic [DIGITS-1:0]   r_sh_dot;
    logic [DIGITS-1:0]   r_sh_en;
    logic                r_sh_lz;

    logic [DIGITS-1:0]   r_an;
    logic [6:0]          r_a2g;
    logic                r_dp;
    logic                r_frame_start;

    logic                w_frame_edge;
    logic [IDX_W-1:0]    w_msd;
    logic [3:0]          w_nibble;
    logic [6:0]          w_seg;
    logic                w_visible;

    // ---------------- slot state machine ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_idx_next   = r_idx;
        unique case (r_state)
            BLANK: begin
                if (r_cnt == C_BLANK_LAST) begin
                    w_state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (r_cnt == C_SLOT_LAST) begin
                    w_state_next = BLANK;
                    w_cnt_next   = '0;
                    w_idx_next   = (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;
                end
            end
            default: begin
                w_state_next = BLANK;
                w_cnt_next   = '0;
                w_idx_next   = '0;
            end
        endcase
    end

    assign w_frame_edge = (r_state == BLANK) && (r_idx == '0) && (r_cnt == '0);

    // ---------------- frame snapshot ----------------
    // Inputs are sampled only at the frame boundary so a frame never tears.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh_data <= '0;
            r_sh_dot  <= '0;
            r_sh_en   <= '0;
            r_sh_lz   <= 1'b0;
        end else if (w_frame_edge) begin
            r_sh_data <= bus.data;
            r_sh_dot  <= bus.dot;
            r_sh_en   <= bus.digit_en;
            r_sh_lz   <= bus.lz_blank;
        end
    end

    // Highest nonzero nibble wins; all-zero data leaves msd at 0.
    always_comb begin
        w_msd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_sh_data[4*i +: 4] != 4'h0) begin
                w_msd = IDX_W'(i);
            end
        end
    end

    assign w_nibble  = r_sh_data[{r_idx, 2'b00} +: 4];
    assign w_visible = r_sh_en[r_idx] &&
                       !(r_sh_lz && (r_idx != '0) && (r_idx > w_msd));

    seg7_scan_dec u_dec (
        .nibble (w_nibble),
        .seg    (w_seg)
    );

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an          <= '1;
            r_a2g         <= SEG_OFF;
            r_dp          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_frame_edge;
            if ((r_state == DRIVE) && w_visible) begin
                r_an  <= ~(DIGITS'(1) << r_idx);
                r_a2g <= w_seg;
                r_dp  <= ~r_sh_dot[r_idx];
            end else begin
                r_an  <= '1;
                r_a2g <= SEG_OFF;
                r_dp  <= 1'b1;
            end
        end
    end

    assign bus.an          = r_an;
    assign bus.a2g         = r_a2g;
    assign bus.dp          = r_dp;
    assign bus.frame_start = r_frame_start;

endmodule : seg7_scan
`default_nettype wire
